// File: rtl/prim_rr_arb_sched.sv
// Round-robin scheduler: N requesters share one valid/ready sink through a registered
// payload/index slice, returning a one-cycle grant when the sink accepts.
module prim_rr_arb_sched #(
   parameter  int N    = 4,
   parameter  int DW   = 8,
   localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N-1:0]      req_i,
   input  logic [N*DW-1:0]   data_i,
   output logic [N-1:0]      gnt_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DW-1:0]     data_o,
   output logic [IdxW-1:0]   idx_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   logic [IdxW-1:0]   ptr;
   logic [IdxW-1:0]   idx_q;
   logic [DW-1:0]     data_q;
   logic              valid_q;

   logic              accept;
   logic [IdxW-1:0]   nxt_ptr;
   logic [IdxW-1:0]   arb_ptr;
   logic [N-1:0]      arb_req;
   logic [IdxW-1:0]   cand;
   logic [IdxW-1:0]   winner;
   logic              found;

   assign nxt_ptr = (idx_q == IdxW'(N - 1)) ? '0 : idx_q + 1'b1;

   // On an accepted transfer, arbitration already sees the advanced pointer and skips
   // the requester being granted, so a new winner can load in the same cycle.
   always_comb begin
      accept  = valid_q & ready_i;
      arb_ptr = accept ? nxt_ptr : ptr;
      arb_req = req_i;
      if (accept) arb_req[idx_q] = 1'b0;
      cand   = '0;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand = IdxW'((int'(arb_ptr) + i) % N);
         if (!found && arb_req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         ptr     <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  data_q  <= data_i[int'(winner)*DW +: DW];
                  idx_q   <= winner;
                  valid_q <= 1'b1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (ready_i) begin
                  ptr <= nxt_ptr;
                  if (found) begin
                     data_q <= data_i[int'(winner)*DW +: DW];
                     idx_q  <= winner;
                  end else begin
                     valid_q <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset suppresses the grant of a transfer that is being accepted in the same cycle.
   assign gnt_o   = (accept && !rst_i) ? (N'(1) << idx_q) : '0;
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign idx_o   = idx_q;

   // A requester must hold its request until its latched payload is granted.
   req_held_while_busy: assert property (@(posedge clk_i) disable iff (rst_i) valid_q |-> req_i[idx_q]);

endmodule
